// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the load/store memory access controller:
// RV32I funct3 encodings and the controller FSM state type.
package mem_ctrl_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/mem_lane.sv
// Byte-lane alignment: enables, store replication, load extraction,
// extension and legality/alignment decode for one access.
module mem_lane (
    input  logic [2:0]  funct3_i,
    input  logic        we_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o,
    output logic        illegal_o
);
    import mem_ctrl_pkg::*;

    logic [31:0] shifted;

    assign shifted = rdata_i >> {off_i, 3'b000};

    // Access size is carried in funct3[1:0] for loads and stores alike.
    always_comb begin
        be_o         = 4'b0000;
        wdata_o      = wdata_i;
        misaligned_o = 1'b0;
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_o         = 4'b0011 << off_i;
                wdata_o      = {2{wdata_i[15:0]}};
                misaligned_o = off_i[0];
            end
            2'b10: begin
                be_o         = 4'b1111;
                misaligned_o = (off_i != 2'b00);
            end
            default: be_o = 4'b0000;
        endcase
    end

    always_comb begin
        illegal_o = 1'b0;
        if (we_i) begin
            illegal_o = !(funct3_i inside {F3_SB, F3_SH, F3_SW});
        end else begin
            illegal_o = (funct3_i inside {3'b011, 3'b110, 3'b111});
        end
    end

    always_comb begin
        rdata_o = 32'h0;
        case (funct3_i)
            F3_LB:   rdata_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   rdata_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   rdata_o = shifted;
            F3_LBU:  rdata_o = {24'h0, shifted[7:0]};
            F3_LHU:  rdata_o = {16'h0, shifted[15:0]};
            default: rdata_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store controller between the core LSU and a
// word-addressed memory port with ack handshake and timeout.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    import mem_ctrl_pkg::*;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e      state_q;
    logic [CW-1:0] cnt_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_wdata_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;

    logic        idle;
    logic [2:0]  lane_f3;
    logic        lane_we;
    logic [1:0]  lane_off;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;
    logic        lane_mis;
    logic        lane_ill;
    logic        tmo_hit;

    // The lane decodes the incoming request in IDLE and the held one after.
    assign idle     = (state_q == IDLE);
    assign lane_f3  = idle ? req_funct3  : f3_q;
    assign lane_we  = idle ? req_we      : we_q;
    assign lane_off = idle ? req_addr[1:0] : off_q;
    assign tmo_hit  = (cnt_q == CW'(TIMEOUT - 1));

    mem_lane u_lane (
        .funct3_i     (lane_f3),
        .we_i         (lane_we),
        .off_i        (lane_off),
        .wdata_i      (req_wdata),
        .rdata_i      (mem_rdata),
        .be_o         (lane_be),
        .wdata_o      (lane_wdata),
        .rdata_o      (lane_rdata),
        .misaligned_o (lane_mis),
        .illegal_o    (lane_ill)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            f3_q         <= 3'b000;
            off_q        <= 2'b00;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_be_q     <= 4'b0000;
            mem_wdata_q  <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_we;
                        f3_q        <= req_funct3;
                        off_q       <= req_addr[1:0];
                        mem_addr_q  <= {req_addr[31:2], 2'b00};
                        mem_wdata_q <= lane_wdata;
                        if (lane_mis || lane_ill) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0;
                        end else begin
                            state_q   <= ACCESS;
                            cnt_q     <= '0;
                            mem_req_q <= 1'b1;
                            mem_we_q  <= req_we;
                            mem_be_q  <= lane_be;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack || tmo_hit) begin
                        state_q      <= RESP;
                        mem_req_q    <= 1'b0;
                        mem_we_q     <= 1'b0;
                        mem_be_q     <= 4'b0000;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= !mem_ack;
                        resp_rdata_q <= (mem_ack && !we_q) ? lane_rdata : 32'h0;
                    end
                    if (!mem_ack) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RESP: begin
                    state_q    <= IDLE;
                    resp_err_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = idle;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with TIMEOUT = 4.
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_chk;
    int n_err;

    mem_access_ctrl #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one request; returns 1ns after the accepting edge.
    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // n ACCESS cycles without ack after the current one, then ack.
    task automatic ack_at(input int n, input logic [31:0] rd);
        repeat (n) @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic resp_chk(input string tag, input logic err,
                            input logic [31:0] rd);
        chk({tag, ".rv"},   {31'h0, resp_valid}, 32'h1);
        chk({tag, ".err"},  {31'h0, resp_err},   {31'h0, err});
        chk({tag, ".rd"},   resp_rdata,          rd);
        chk({tag, ".mreq"}, {31'h0, mem_req},    32'h0);
        @(negedge clk);
        chk({tag, ".rv1"},  {31'h0, resp_valid}, 32'h0);
        chk({tag, ".rdy"},  {31'h0, req_ready},  32'h1);
    endtask

    task automatic mem_chk(input string tag, input logic we,
                           input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] wd);
        @(negedge clk);
        chk({tag, ".mreq"}, {31'h0, mem_req},   32'h1);
        chk({tag, ".mwe"},  {31'h0, mem_we},    {31'h0, we});
        chk({tag, ".addr"}, mem_addr,           a);
        chk({tag, ".be"},   {28'h0, mem_be},    {28'h0, be});
        if (we) chk({tag, ".wd"}, mem_wdata, wd);
        chk({tag, ".rdy"},  {31'h0, req_ready}, 32'h0);
    endtask

    task automatic load(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] rd, input logic [31:0] exp);
        issue(1'b0, f3, a, 32'h0);
        mem_chk(tag, 1'b0, {a[31:2], 2'b00}, be, 32'h0);
        ack_at(0, rd);
        resp_chk(tag, 1'b0, exp);
    endtask

    task automatic bad(input string tag, input logic we,
                       input logic [2:0] f3, input logic [31:0] a);
        issue(we, f3, a, 32'h1234_5678);
        @(negedge clk);
        resp_chk(tag, 1'b1, 32'h0);
    endtask

    logic seen;

    initial begin
        n_chk      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;

        @(negedge clk);
        chk("rst.rdy",  {31'h0, req_ready},  32'h1);
        chk("rst.mreq", {31'h0, mem_req},    32'h0);
        chk("rst.rv",   {31'h0, resp_valid}, 32'h0);
        chk("rst.be",   {28'h0, mem_be},     32'h0);
        chk("rst.addr", mem_addr,            32'h0);
        chk("rst.rd",   resp_rdata,          32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // SB with a second request held during the access: it must be dropped.
        issue(1'b1, F3_SB, 32'h0000_0103, 32'h0000_00A5);
        mem_chk("sb", 1'b1, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = F3_LW;
        req_addr   = 32'h0000_0400;
        ack_at(1, 32'hFFFF_FFFF);
        req_valid = 1'b0;
        resp_chk("sb", 1'b0, 32'h0);
        @(negedge clk);
        chk("noq.mreq", {31'h0, mem_req}, 32'h0);

        issue(1'b1, F3_SH, 32'h0000_0102, 32'h1234_ABCD);
        mem_chk("sh", 1'b1, 32'h0000_0100, 4'b1100, 32'hABCD_ABCD);
        ack_at(0, 32'h0);
        resp_chk("sh", 1'b0, 32'h0);

        load("lh",  F3_LH,  32'h0000_0202, 4'b1100, 32'h8001_0000, 32'hFFFF_8001);
        load("lhu", F3_LHU, 32'h0000_0202, 4'b1100, 32'h8001_0000, 32'h0000_8001);
        load("lb",  F3_LB,  32'h0000_0101, 4'b0010, 32'h0000_8000, 32'hFFFF_FF80);
        load("lbu", F3_LBU, 32'h0000_0103, 4'b1000, 32'h7F00_0000, 32'h0000_007F);
        load("lw",  F3_LW,  32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        load("lb3", F3_LB,  32'h0000_0203, 4'b1000, 32'h8100_0000, 32'hFFFF_FF81);

        bad("swmis",  1'b1, F3_SW,  32'h0000_0006);
        bad("lhmis",  1'b0, F3_LH,  32'h0000_0201);
        bad("ld011",  1'b0, 3'b011, 32'h0000_0000);
        bad("st100",  1'b1, 3'b100, 32'h0000_0000);

        // Timeout: mem_req held for exactly 4 ACCESS cycles.
        issue(1'b0, F3_LW, 32'h0000_0040, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("tmo.mreq%0d", i), {31'h0, mem_req}, 32'h1);
        end
        @(negedge clk);
        resp_chk("tmo", 1'b1, 32'h0);

        // Ack on the cycle the timeout would fire: ack wins.
        issue(1'b0, F3_LW, 32'h0000_0044, 32'h0);
        @(negedge clk);
        ack_at(3, 32'h1122_3344);
        resp_chk("tmoack", 1'b0, 32'h1122_3344);

        // Stray ack in IDLE.
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idleack.rv", {31'h0, resp_valid}, 32'h0);
        chk("idleack.rdy", {31'h0, req_ready}, 32'h1);

        // Reset mid-ACCESS.
        issue(1'b0, F3_LW, 32'h0000_0050, 32'h0);
        @(negedge clk);
        chk("rma.mreq0", {31'h0, mem_req}, 32'h1);
        #2 rst_n = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_5555;
        #1;
        chk("rma.mreq", {31'h0, mem_req},   32'h0);
        chk("rma.rdy",  {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen = seen | resp_valid;
        end
        mem_ack = 1'b0;
        chk("rma.norsp", {31'h0, seen}, 32'h0);

        issue(1'b1, F3_SW, 32'h0000_0080, 32'hCAFE_F00D);
        mem_chk("post", 1'b1, 32'h0000_0080, 4'b1111, 32'hCAFE_F00D);
        ack_at(0, 32'h0);
        resp_chk("post", 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
